// File: rtl/vga_entity_renderer_pkg.sv
// Shared codes, VGA timing defaults, colours and the pixel pipeline record
// used by the entity renderer and its timing generator.
`timescale 1ns/1ps
package vga_entity_renderer_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_SQUARE = 16;
    localparam int V_SQUARE = 16;
    localparam int ENT_LAT  = 1;

    typedef enum logic [1:0] {
        ENT_NOTHING    = 2'd0,
        ENT_SNAKE_HEAD = 2'd1,
        ENT_SNAKE_TAIL = 2'd2,
        ENT_APPLE      = 2'd3
    } ent_e;

    typedef enum logic [2:0] {
        STATE_IDLE   = 3'd0,
        STATE_INGAME = 3'd1,
        STATE_PAUSED = 3'd2,
        STATE_TEST   = 3'd7
    } state_e;

    localparam logic [11:0] COL_BG        = 12'h000;
    localparam logic [11:0] COL_HEAD      = 12'h0F0;
    localparam logic [11:0] COL_TAIL      = 12'h0A0;
    localparam logic [11:0] COL_TAIL_EDGE = 12'h040;
    localparam logic [11:0] COL_APPLE     = 12'hF00;
    localparam logic [11:0] COL_LOSE      = 12'h300;
    localparam logic [11:0] COL_WIN       = 12'h030;
    localparam logic [11:0] COL_TEST_TAIL = 12'h00F;

    // Sync pulses are carried active-high so a cleared pipeline means "no pulse".
    typedef struct packed {
        logic       active;
        logic       hs_pulse;
        logic       vs_pulse;
        logic [9:0] sub_x;
        logic [9:0] sub_y;
    } pix_info_t;

    function automatic logic is_edge(input logic [9:0] sub, input int size);
        return (sub == 10'd0) || (int'(sub) == size - 1);
    endfunction

endpackage

// File: rtl/vga_entity_renderer_if.sv
// Coordinate / entity link between the renderer (master) and the game logic.
`timescale 1ns/1ps
interface vga_entity_renderer_if;
    import vga_entity_renderer_pkg::*;

    logic [9:0] x_out;
    logic [9:0] y_out;
    ent_e       entity;
    logic [2:0] game_state;
    logic       game_over;
    logic       game_won;

    modport master (
        output x_out, y_out,
        input  entity, game_state, game_over, game_won
    );

    modport slave (
        input  x_out, y_out,
        output entity, game_state, game_over, game_won
    );

endinterface

// File: rtl/vga_entity_renderer_timing_gen.sv
// Free-running VGA counters with raw (unaligned) syncs, active flag and a
// registered end-of-visible-frame tick.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       active_o,
    output logic       hs_raw_o,
    output logic       vs_raw_o,
    output logic       frame_tick_o
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       tick_q, tick_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
        tick_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_VIS - 10'd1);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign active_o     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs_raw_o     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vs_raw_o     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/vga_entity_renderer.sv
// Renders the game's entity codes to 12-bit VGA colour, keeping syncs and
// blanking aligned with the entity lookup latency of the game logic.
`timescale 1ns/1ps
module vga_entity_renderer
    import vga_entity_renderer_pkg::*;
#(
    parameter int H_ACTIVE = vga_entity_renderer_pkg::H_ACTIVE,
    parameter int H_FP     = vga_entity_renderer_pkg::H_FP,
    parameter int H_SYNC   = vga_entity_renderer_pkg::H_SYNC,
    parameter int H_BP     = vga_entity_renderer_pkg::H_BP,
    parameter int V_ACTIVE = vga_entity_renderer_pkg::V_ACTIVE,
    parameter int V_FP     = vga_entity_renderer_pkg::V_FP,
    parameter int V_SYNC   = vga_entity_renderer_pkg::V_SYNC,
    parameter int V_BP     = vga_entity_renderer_pkg::V_BP,
    parameter int SQ_W     = H_SQUARE,
    parameter int SQ_H     = V_SQUARE,
    parameter int ENT_LAT  = vga_entity_renderer_pkg::ENT_LAT
) (
    input  logic                  vga_clk,
    input  logic                  reset,
    vga_entity_renderer_if.master game,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  display_en,
    output logic [11:0]           rgb,
    output logic                  frame_tick
);

    logic [9:0] h_cnt, v_cnt;
    logic       active, hs_raw, vs_raw;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .vga_clk      (vga_clk),
        .reset        (reset),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .active_o     (active),
        .hs_raw_o     (hs_raw),
        .vs_raw_o     (vs_raw),
        .frame_tick_o (frame_tick)
    );

    assign game.x_out = h_cnt;
    assign game.y_out = v_cnt;

    pix_info_t   pipe_q [ENT_LAT];
    pix_info_t   pipe_d [ENT_LAT];
    pix_info_t   aligned;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q, den_q;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic        edge_x, edge_y;

    // Delay line matching the game logic's lookup latency.
    always_comb begin
        pipe_d[0] = '{active:   active,
                      hs_pulse: !hs_raw,
                      vs_pulse: !vs_raw,
                      sub_x:    h_cnt % 10'(SQ_W),
                      sub_y:    v_cnt % 10'(SQ_H)};
        for (int i = 1; i < ENT_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign aligned = pipe_q[ENT_LAT-1];
    assign edge_x  = is_edge(aligned.sub_x, SQ_W);
    assign edge_y  = is_edge(aligned.sub_y, SQ_H);

    always_comb begin
        rgb_d = COL_BG;
        if (aligned.active && game.game_state == STATE_INGAME) begin
            case (game.entity)
                ENT_SNAKE_HEAD: rgb_d = COL_HEAD;
                ENT_SNAKE_TAIL: rgb_d = (edge_x || edge_y) ? COL_TAIL_EDGE : COL_TAIL;
                ENT_APPLE:      rgb_d = (edge_x && edge_y) ? COL_BG : COL_APPLE;
                default: begin
                    if (game.game_won)
                        rgb_d = COL_WIN;
                    else if (game.game_over && frame_cnt_q[4])
                        rgb_d = COL_LOSE;
                end
            endcase
        end else if (aligned.active && game.game_state == STATE_TEST) begin
            case (game.entity)
                ENT_SNAKE_HEAD: rgb_d = COL_HEAD;
                ENT_SNAKE_TAIL: rgb_d = COL_TEST_TAIL;
                ENT_APPLE:      rgb_d = COL_APPLE;
                default:        rgb_d = COL_BG;
            endcase
        end
        frame_cnt_d = frame_cnt_q + {5'd0, frame_tick};
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENT_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            den_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            for (int i = 0; i < ENT_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            rgb_q       <= rgb_d;
            hsync_q     <= !aligned.hs_pulse;
            vsync_q     <= !aligned.vs_pulse;
            den_q       <= aligned.active;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_en = den_q;

endmodule

// File: tb/tb_vga_entity_renderer.sv
// Directed bench for vga_entity_renderer on a shrunken raster (40x20 clocks,
// 32x16 visible) so that many whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_entity_renderer;
    import vga_entity_renderer_pkg::*;

    localparam int HA = 32, HF = 2, HS = 4, HB = 2;
    localparam int VA = 16, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, display_en, frame_tick;
    logic [11:0] rgb;

    vga_entity_renderer_if gameBus();

    vga_entity_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .game       (gameBus),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_en (display_en),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    always #20 vga_clk = ~vga_clk;

    int checks = 0;
    int failures = 0;
    int entMode = 0;
    int bx, by, d1x, d1y, d2x, d2y;
    int fLose, fWin, fHead, fTailEdge, fTail, fApple, fBlue, fNonzero;
    int fInSq, fBorderEdge, fCornerApple;
    int tDen, tHsLow, tVsLow, tSyncErr, tCoordErr, tTickErr, tTicks;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input state_e st, input logic over, input logic won, input int mode);
        gameBus.game_state = st;
        gameBus.game_over  = over;
        gameBus.game_won   = won;
        entMode            = mode;
    endtask

    // Game-logic stand-in: one square at x 16..31, y 0..15, answered one clock late.
    function automatic ent_e entModel(input int mode, input int x, input int y);
        if (x >= 16 && x < 32 && y < 16) begin
            case (mode)
                1:       return ENT_SNAKE_HEAD;
                2:       return ENT_SNAKE_TAIL;
                3:       return ENT_APPLE;
                default: return ENT_NOTHING;
            endcase
        end
        return ENT_NOTHING;
    endfunction

    initial begin
        int capX, capY;
        gameBus.entity = ENT_NOTHING;
        forever begin
            @(negedge vga_clk);
            capX = int'(gameBus.x_out);
            capY = int'(gameBus.y_out);
            @(posedge vga_clk);
            #1;
            gameBus.entity = entModel(entMode, capX, capY);
        end
    end

    task automatic stepCycle();
        @(negedge vga_clk);
        d2x = d1x; d2y = d1y;
        d1x = bx;  d1y = by;
        if (bx == HT - 1) begin
            bx = 0;
            by = (by == VT - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic sampleCycle();
        logic vis, expHs, expVs, expTick, inSq, border, corner;
        int sx, sy;
        if (int'(gameBus.x_out) != bx || int'(gameBus.y_out) != by) tCoordErr++;
        vis     = (d2x < HA) && (d2y < VA);
        expHs   = !((d2x >= HA + HF) && (d2x < HA + HF + HS));
        expVs   = !((d2y >= VA + VF) && (d2y < VA + VF + VS));
        expTick = (d1x == HT - 1) && (d1y == VA - 1);
        if (display_en != vis || hsync != expHs || vsync != expVs) tSyncErr++;
        if (frame_tick != expTick) tTickErr++;
        if (frame_tick) tTicks++;
        if (display_en) tDen++;
        if (!hsync) tHsLow++;
        if (!vsync) tVsLow++;
        inSq   = (d2x >= 16) && (d2x < 32) && (d2y < 16);
        sx     = d2x - 16;
        sy     = d2y;
        border = (sx == 0) || (sx == 15) || (sy == 0) || (sy == 15);
        corner = ((sx == 0) || (sx == 15)) && ((sy == 0) || (sy == 15));
        if (rgb != 12'h000) fNonzero++;
        if (rgb != 12'h000 && inSq) fInSq++;
        if (rgb == 12'h300) fLose++;
        if (rgb == 12'h030) fWin++;
        if (rgb == 12'h0F0) fHead++;
        if (rgb == 12'h0A0) fTail++;
        if (rgb == 12'h00F) fBlue++;
        if (rgb == 12'hF00) fApple++;
        if (rgb == 12'h040) fTailEdge++;
        if (rgb == 12'h040 && inSq && border) fBorderEdge++;
        if (rgb == 12'hF00 && inSq && corner) fCornerApple++;
    endtask

    task automatic runFrame();
        fLose = 0; fWin = 0; fHead = 0; fTailEdge = 0; fTail = 0; fApple = 0;
        fBlue = 0; fNonzero = 0; fInSq = 0; fBorderEdge = 0; fCornerApple = 0;
        for (int i = 0; i < HT * VT; i++) begin
            stepCycle();
            sampleCycle();
        end
    endtask

    initial begin
        int  k, tickSeen;
        logic found;
        tDen = 0; tHsLow = 0; tVsLow = 0; tSyncErr = 0;
        tCoordErr = 0; tTickErr = 0; tTicks = 0;
        reset = 1'b1;
        applyStimulus(STATE_INGAME, 1'b1, 1'b0, 0);
        repeat (3) @(negedge vga_clk);
        checkOutput("rst_x_out", int'(gameBus.x_out), 0);
        checkOutput("rst_y_out", int'(gameBus.y_out), 0);
        checkOutput("rst_hsync", int'(hsync), 1);
        checkOutput("rst_vsync", int'(vsync), 1);
        checkOutput("rst_den", int'(display_en), 0);
        checkOutput("rst_rgb", int'(rgb), 0);
        checkOutput("rst_tick", int'(frame_tick), 0);

        reset = 1'b0;
        bx = 0; by = 0; d1x = 0; d1y = 0; d2x = 0; d2y = 0;
        stepCycle();

        // Lose blink: frame n after reset shows frame_cnt n.
        for (int f = 0; f < 34; f++) begin
            runFrame();
            checkOutput($sformatf("blink_f%0d", f), fLose, (f >= 16 && f < 32) ? HA * VA : 0);
        end
        checkOutput("den_total", tDen, 34 * HA * VA);
        checkOutput("hs_low_total", tHsLow, 34 * VT * HS);
        checkOutput("vs_low_total", tVsLow, 34 * HT * VS);
        checkOutput("sync_align_err", tSyncErr, 0);
        checkOutput("coord_err", tCoordErr, 0);
        checkOutput("tick_align_err", tTickErr, 0);
        checkOutput("tick_count", tTicks, 34);

        applyStimulus(STATE_INGAME, 1'b0, 1'b0, 1);
        runFrame();
        checkOutput("head_count", fHead, 256);
        checkOutput("head_nonzero", fNonzero, 256);
        checkOutput("head_in_square", fInSq, 256);

        applyStimulus(STATE_INGAME, 1'b0, 1'b0, 2);
        runFrame();
        checkOutput("tail_edge_count", fTailEdge, 60);
        checkOutput("tail_inner_count", fTail, 196);
        checkOutput("tail_edge_on_border", fBorderEdge, 60);
        checkOutput("tail_nonzero", fNonzero, 256);

        applyStimulus(STATE_INGAME, 1'b0, 1'b0, 3);
        runFrame();
        checkOutput("apple_count", fApple, 252);
        checkOutput("apple_corner", fCornerApple, 0);
        checkOutput("apple_in_square", fInSq, 252);
        checkOutput("apple_nonzero", fNonzero, 252);

        applyStimulus(STATE_TEST, 1'b1, 1'b1, 2);
        runFrame();
        checkOutput("test_tail_blue", fBlue, 256);
        checkOutput("test_nonzero", fNonzero, 256);

        applyStimulus(STATE_IDLE, 1'b0, 1'b0, 1);
        runFrame();
        checkOutput("idle_nonzero", fNonzero, 0);

        applyStimulus(STATE_INGAME, 1'b1, 1'b1, 1);
        runFrame();
        checkOutput("won_background", fWin, HA * VA - 256);
        checkOutput("won_head_kept", fHead, 256);
        checkOutput("won_no_lose", fLose, 0);

        // Reset in the middle of a visible line inside the head square.
        found = 1'b0;
        for (int i = 0; i < HT * VT && !found; i++) begin
            @(negedge vga_clk);
            if (gameBus.x_out == 10'd20 && gameBus.y_out == 10'd10) found = 1'b1;
        end
        checkOutput("reach_20_10", int'(found), 1);
        checkOutput("pre_reset_rgb", int'(rgb), 12'h0F0);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_x_out", int'(gameBus.x_out), 0);
        checkOutput("mid_rst_y_out", int'(gameBus.y_out), 0);
        checkOutput("mid_rst_hsync", int'(hsync), 1);
        checkOutput("mid_rst_vsync", int'(vsync), 1);
        checkOutput("mid_rst_den", int'(display_en), 0);
        checkOutput("mid_rst_rgb", int'(rgb), 0);
        checkOutput("mid_rst_tick", int'(frame_tick), 0);
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;
        k = 0;
        tickSeen = 0;
        while (!(int'(gameBus.x_out) == HT - 1 && int'(gameBus.y_out) == VA - 1) && k < 2 * HT * VT) begin
            @(negedge vga_clk);
            k++;
            if (frame_tick) tickSeen++;
        end
        checkOutput("cycles_to_last_visible", k, (VA - 1) * HT + HT - 1);
        checkOutput("no_partial_tick", tickSeen, 0);
        @(negedge vga_clk);
        checkOutput("tick_after_reset", int'(frame_tick), 1);
        @(negedge vga_clk);
        checkOutput("tick_one_cycle", int'(frame_tick), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
